// File: rtl/selecionar_ativo.sv
// Picks the lowest-index active slot whose criterion equals the classifier minimum,
// presents it over a valid/accept handshake, then requests that slot be deactivated.
module selecionar_ativo #(
  parameter int NUM_NA         = 8,
  parameter int ADR_WIDTH      = 8,
  parameter int CRITERIO_WIDTH = 5,
  parameter int IDX_WIDTH      = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ca_pronto_in,
  input  logic [CRITERIO_WIDTH-1:0]        ca_criterio_geral_in,
  input  logic [NUM_NA-1:0]                na_ativo_in,
  input  logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio_in,
  input  logic [NUM_NA*ADR_WIDTH-1:0]      na_endereco_in,
  input  logic                             sa_aceito_in,
  output logic                             sa_valido_out,
  output logic [IDX_WIDTH-1:0]             sa_indice_out,
  output logic [ADR_WIDTH-1:0]             sa_endereco_out,
  output logic [CRITERIO_WIDTH-1:0]        sa_criterio_out,
  output logic                             sa_vazio_out,
  output logic                             sa_desativar_out,
  output logic [IDX_WIDTH-1:0]             sa_desativar_idx_out
);

  typedef enum logic [1:0] {
    OCIOSO,
    BUSCA,
    ENTREGA
  } estado_t;

  localparam logic [IDX_WIDTH-1:0] ULTIMO = IDX_WIDTH'(NUM_NA - 1);

  estado_t                   estado, estado_n;
  logic [IDX_WIDTH-1:0]      cnt, cnt_n;
  logic                      pronto_d;
  logic                      valido_n, vazio_n, desativar_n;
  logic [IDX_WIDTH-1:0]      indice_n, desativar_idx_n;
  logic [ADR_WIDTH-1:0]      endereco_n;
  logic [CRITERIO_WIDTH-1:0] criterio_n;

  logic [CRITERIO_WIDTH-1:0] crit_arr [NUM_NA];
  logic [ADR_WIDTH-1:0]      adr_arr  [NUM_NA];
  logic                      inicio, casa;

  always_comb begin
    for (int i = 0; i < NUM_NA; i++) begin
      crit_arr[i] = na_criterio_in[i*CRITERIO_WIDTH +: CRITERIO_WIDTH];
      adr_arr[i]  = na_endereco_in[i*ADR_WIDTH +: ADR_WIDTH];
    end
  end

  assign inicio = ca_pronto_in & ~pronto_d;
  assign casa   = na_ativo_in[cnt] && (crit_arr[cnt] == ca_criterio_geral_in);

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    estado_n        = estado;
    cnt_n           = cnt;
    valido_n        = sa_valido_out;
    indice_n        = sa_indice_out;
    endereco_n      = sa_endereco_out;
    criterio_n      = sa_criterio_out;
    vazio_n         = sa_vazio_out;
    desativar_n     = 1'b0;
    desativar_idx_n = '0;

    unique case (estado)
      OCIOSO: begin
        if (inicio) begin
          vazio_n  = 1'b0;
          cnt_n    = '0;
          estado_n = BUSCA;
        end
      end
      BUSCA: begin
        // A dropped pronto means the classifier restarted; its minimum is stale.
        if (!ca_pronto_in) begin
          estado_n = OCIOSO;
        end else if (casa) begin
          indice_n   = cnt;
          endereco_n = adr_arr[cnt];
          criterio_n = crit_arr[cnt];
          valido_n   = 1'b1;
          estado_n   = ENTREGA;
        end else if (cnt == ULTIMO) begin
          vazio_n  = 1'b1;
          estado_n = OCIOSO;
        end else begin
          cnt_n = cnt + IDX_WIDTH'(1);
        end
      end
      ENTREGA: begin
        if (sa_aceito_in) begin
          valido_n        = 1'b0;
          indice_n        = '0;
          endereco_n      = '0;
          criterio_n      = '0;
          desativar_n     = 1'b1;
          desativar_idx_n = sa_indice_out;
          estado_n        = OCIOSO;
        end
      end
      default: estado_n = OCIOSO;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado               <= OCIOSO;
      cnt                  <= '0;
      pronto_d             <= 1'b0;
      sa_valido_out        <= 1'b0;
      sa_indice_out        <= '0;
      sa_endereco_out      <= '0;
      sa_criterio_out      <= '0;
      sa_vazio_out         <= 1'b0;
      sa_desativar_out     <= 1'b0;
      sa_desativar_idx_out <= '0;
    end else begin
      estado               <= estado_n;
      cnt                  <= cnt_n;
      pronto_d             <= ca_pronto_in;
      sa_valido_out        <= valido_n;
      sa_indice_out        <= indice_n;
      sa_endereco_out      <= endereco_n;
      sa_criterio_out      <= criterio_n;
      sa_vazio_out         <= vazio_n;
      sa_desativar_out     <= desativar_n;
      sa_desativar_idx_out <= desativar_idx_n;
    end
  end

endmodule

// File: tb/tb_selecionar_ativo.sv
// Scoreboard bench for selecionar_ativo: directed scenarios push expected winners,
// deactivations and empty-scan events; a negedge monitor pops and compares them.
module tb_selecionar_ativo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ca_pronto_in = 1'b0;
  logic [4:0]  ca_criterio_geral_in = '0;
  logic [7:0]  na_ativo_in = '0;
  logic [39:0] na_criterio_in = '0;
  logic [63:0] na_endereco_in = '0;
  logic        sa_aceito_in = 1'b0;
  logic        sa_valido_out, sa_vazio_out, sa_desativar_out;
  logic [2:0]  sa_indice_out, sa_desativar_idx_out;
  logic [7:0]  sa_endereco_out;
  logic [4:0]  sa_criterio_out;

  selecionar_ativo dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .ca_pronto_in         (ca_pronto_in),
    .ca_criterio_geral_in (ca_criterio_geral_in),
    .na_ativo_in          (na_ativo_in),
    .na_criterio_in       (na_criterio_in),
    .na_endereco_in       (na_endereco_in),
    .sa_aceito_in         (sa_aceito_in),
    .sa_valido_out        (sa_valido_out),
    .sa_indice_out        (sa_indice_out),
    .sa_endereco_out      (sa_endereco_out),
    .sa_criterio_out      (sa_criterio_out),
    .sa_vazio_out         (sa_vazio_out),
    .sa_desativar_out     (sa_desativar_out),
    .sa_desativar_idx_out (sa_desativar_idx_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] adr;
    logic [4:0] crit;
    int         lat;  // rising edges from the start edge until the output is seen
  } exp_t;

  exp_t       win_q[$];
  logic [2:0] deact_q[$];
  int         vazio_q[$];
  exp_t       cur;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectations.
  logic valido_prev = 1'b0, vazio_prev = 1'b0, desativar_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      valido_prev = 1'b0; vazio_prev = 1'b0; desativar_prev = 1'b0;
    end else begin
      if (sa_valido_out && !valido_prev) begin
        if (win_q.size() == 0) check("unexpected valid", 1, 0);
        else begin
          cur = win_q.pop_front();
          check("win indice", 32'(sa_indice_out), 32'(cur.idx));
          check("win endereco", 32'(sa_endereco_out), 32'(cur.adr));
          check("win criterio", 32'(sa_criterio_out), 32'(cur.crit));
          check("win latency", 32'(cyc - start_cyc), 32'(cur.lat));
        end
      end else if (sa_valido_out) begin
        check("held indice", 32'(sa_indice_out), 32'(cur.idx));
        check("held endereco", 32'(sa_endereco_out), 32'(cur.adr));
        check("held criterio", 32'(sa_criterio_out), 32'(cur.crit));
      end
      if (sa_desativar_out) begin
        if (desativar_prev) check("desativar one cycle", 1, 0);
        else if (deact_q.size() == 0) check("unexpected desativar", 1, 0);
        else check("desativar idx", 32'(sa_desativar_idx_out), 32'(deact_q.pop_front()));
      end
      if (sa_vazio_out && !vazio_prev) begin
        if (vazio_q.size() == 0) check("unexpected vazio", 1, 0);
        else check("vazio latency", 32'(cyc - start_cyc), 32'(vazio_q.pop_front()));
      end
      valido_prev    = sa_valido_out;
      vazio_prev     = sa_vazio_out;
      desativar_prev = sa_desativar_out;
    end
  end

  task automatic clear_slots();
    na_ativo_in = '0;
    na_criterio_in = '0;
    for (int i = 0; i < 8; i++) na_endereco_in[i*8 +: 8] = 8'hA0 + 8'(i * 3);
  endtask

  task automatic set_slot(input int i, input logic [4:0] c);
    na_ativo_in[i] = 1'b1;
    na_criterio_in[i*5 +: 5] = c;
  endtask

  function automatic logic [7:0] adr_of(input int i);
    return 8'hA0 + 8'(i * 3);
  endfunction

  // Creates a rising pronto edge; returns just after the start edge.
  task automatic start(input logic [4:0] minimo);
    @(negedge clk);
    ca_pronto_in = 1'b0;
    @(negedge clk);
    ca_criterio_geral_in = minimo;
    ca_pronto_in = 1'b1;
    @(posedge clk);
    #1 start_cyc = cyc;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!sa_valido_out && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!sa_valido_out) check("timeout waiting valid", 0, 1);
  endtask

  task automatic accept();
    @(negedge clk);
    sa_aceito_in = 1'b1;
    @(negedge clk);
    sa_aceito_in = 1'b0;
    check("valid low after accept", 32'(sa_valido_out), 0);
    check("desativar high after accept", 32'(sa_desativar_out), 1);
    @(negedge clk);
    check("desativar low 2nd cycle", 32'(sa_desativar_out), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " valido"}, 32'(sa_valido_out), 0);
    check({tag, " indice"}, 32'(sa_indice_out), 0);
    check({tag, " endereco"}, 32'(sa_endereco_out), 0);
    check({tag, " criterio"}, 32'(sa_criterio_out), 0);
    check({tag, " vazio"}, 32'(sa_vazio_out), 0);
    check({tag, " desativar"}, 32'(sa_desativar_out), 0);
  endtask

  initial begin
    clear_slots();
    #12 check_all_zero("reset");
    rst_n = 1'b1;

    // Single match: slot 4 (crit 3) beats slot 2 (crit 9); min 3.
    set_slot(2, 5'd9);
    set_slot(4, 5'd3);
    win_q.push_back('{3'd4, adr_of(4), 5'd3, 5});
    start(5'd3);
    wait_valid(20);
    deact_q.push_back(3'd4);
    accept();

    // Tie: slots 1 and 6 both crit 7; lowest index wins.
    clear_slots();
    set_slot(1, 5'd7);
    set_slot(6, 5'd7);
    win_q.push_back('{3'd1, adr_of(1), 5'd7, 2});
    start(5'd7);
    wait_valid(20);
    deact_q.push_back(3'd1);
    accept();

    // No match: only slot 7 active with crit 12, min 5.
    clear_slots();
    set_slot(7, 5'd12);
    vazio_q.push_back(8);
    start(5'd5);
    repeat (12) @(negedge clk);
    check("vazio held", 32'(sa_vazio_out), 1);
    check("no valid on empty scan", 32'(sa_valido_out), 0);

    // Backpressure: winner on slot 0, pronto toggles while not accepted.
    clear_slots();
    set_slot(0, 5'd2);
    set_slot(3, 5'd2);
    win_q.push_back('{3'd0, adr_of(0), 5'd2, 1});
    start(5'd2);
    check("vazio cleared by start", 32'(sa_vazio_out), 0);
    wait_valid(20);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ca_pronto_in = ~ca_pronto_in;
    end
    check("valid held under backpressure", 32'(sa_valido_out), 1);
    ca_pronto_in = 1'b0;
    deact_q.push_back(3'd0);
    accept();

    // Abort: drop pronto while slot 2 is examined, before matching slot 5.
    clear_slots();
    set_slot(5, 5'd5);
    start(5'd5);
    @(posedge clk);
    @(posedge clk);
    #1 ca_pronto_in = 1'b0;
    repeat (10) @(negedge clk);
    check_all_zero("abort");
    win_q.push_back('{3'd5, adr_of(5), 5'd5, 6});
    start(5'd5);
    wait_valid(20);

    // Reset in ENTREGA, away from any clock edge.
    #2 rst_n = 1'b0;
    #1 check_all_zero("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    clear_slots();
    set_slot(3, 5'd1);
    win_q.push_back('{3'd3, adr_of(3), 5'd1, 4});
    start(5'd1);
    wait_valid(20);
    deact_q.push_back(3'd3);
    accept();

    repeat (5) @(negedge clk);
    check("win queue drained", 32'(win_q.size()), 0);
    check("deact queue drained", 32'(deact_q.size()), 0);
    check("vazio queue drained", 32'(vazio_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
